// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock, valid/ready on both sides.
// Optional macro BCD_OVF_EN adds a sticky ovf output and forces bcd_out to all 9s on overflow.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIN_W-1:0]    bin_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] bcd_out
`ifdef BCD_OVF_EN
  ,
  output logic                ovf
`endif
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [BIN_W-1:0] r_bin;
  logic [BCD_W-1:0] r_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic [BCD_W-1:0] r_bcd_out;
  logic             r_in_ready;
  logic             r_out_valid;

  // Every digit >= 5 gets +3 in its own 4-bit lane; digits never carry into each other.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    logic [3:0]       d;
    res = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      d = bcd[4*i +: 4];
      if (d >= 4'd5) res[4*i +: 4] = d + 4'd3;
    end
    return res;
  endfunction

  function automatic logic [BCD_W-1:0] all_nines();
    return {DIGITS{4'h9}};
  endfunction

  logic [BCD_W-1:0]       w_bcd_adj;
  logic [BCD_W+BIN_W-1:0] w_shifted;
  logic [BCD_W-1:0]       w_bcd_next;
  logic [BIN_W-1:0]       w_bin_next;
  logic                   w_last;

  // The joint {bcd,bin} shift drops the top BCD bit; that bit is the overflow indication.
  assign w_bcd_adj  = add3_digits(r_bcd);
  assign w_shifted  = {w_bcd_adj, r_bin} << 1;
  assign w_bcd_next = w_shifted[BCD_W+BIN_W-1:BIN_W];
  assign w_bin_next = w_shifted[BIN_W-1:0];
  assign w_last     = (r_cnt == LAST_CNT);

`ifdef BCD_OVF_EN
  logic r_ovf;
  logic w_ovf_next;
  assign w_ovf_next = r_ovf | w_bcd_adj[BCD_W-1];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_bin       <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_bcd_out   <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef BCD_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_bin      <= bin_in;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= SHIFT;
`ifdef BCD_OVF_EN
            r_ovf      <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          r_bin <= w_bin_next;
          r_bcd <= w_bcd_next;
          r_cnt <= r_cnt + 1'b1;
`ifdef BCD_OVF_EN
          r_ovf <= w_ovf_next;
`endif
          if (w_last) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
`ifdef BCD_OVF_EN
            r_bcd_out   <= w_ovf_next ? all_nines() : w_bcd_next;
`else
            r_bcd_out   <= w_bcd_next;
`endif
          end
        end
        DONE: begin
          // No same-cycle handoff: a new accept is only possible one cycle after the output handshake.
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign bcd_out   = r_bcd_out;
`ifdef BCD_OVF_EN
  assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: a 32-bit/10-digit instance and an 8-bit/2-digit truncating instance.
module tb_bin_to_bcd_seq;

  localparam int BIN_W   = 32;
  localparam int DIGITS  = 10;
  localparam int S_BIN_W = 8;
  localparam int S_DIG   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset_n;
  logic                  in_valid, in_ready, out_valid, out_ready;
  logic [BIN_W-1:0]      bin_in;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [S_BIN_W-1:0]    s_bin_in;
  logic [4*S_DIG-1:0]    s_bcd_out;
`ifdef BCD_OVF_EN
  logic                  ovf, s_ovf;
`endif

  int checks   = 0;
  int failures = 0;

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .bin_in(bin_in),
    .out_valid(out_valid), .out_ready(out_ready), .bcd_out(bcd_out)
`ifdef BCD_OVF_EN
    , .ovf(ovf)
`endif
  );

  bin_to_bcd_seq #(.BIN_W(S_BIN_W), .DIGITS(S_DIG)) dut_s (
    .clk(clk), .reset_n(reset_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .bin_in(s_bin_in),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .bcd_out(s_bcd_out)
`ifdef BCD_OVF_EN
    , .ovf(s_ovf)
`endif
  );

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference: decimal digits by repeated division, keeping the low 'digits' digits.
  function automatic logic [63:0] to_bcd(input longint unsigned v, input int digits);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic accept_main(input logic [BIN_W-1:0] v);
    int n;
    n = 0;
    in_valid = 1'b1;
    bin_in   = v;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid_main(output int lat, input bit noise);
    lat = 0;
    while (!out_valid && lat < 200) begin
      if (noise) begin
        in_valid = 1'b1;
        bin_in   = $urandom;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_main(input logic [BIN_W-1:0] v, input logic [63:0] exp, input string name);
    int lat;
    accept_main(v);
    wait_valid_main(lat, 1'b0);
    check({name, " latency"}, 64'(lat), 64'(BIN_W));
    check({name, " bcd"}, 64'(bcd_out), exp);
`ifdef BCD_OVF_EN
    check({name, " ovf"}, {63'd0, ovf}, 64'd0);
`endif
    out_ready = 1'b1;
    @(negedge clk);
    check({name, " valid drop"}, {63'd0, out_valid}, 64'd0);
    check({name, " ready back"}, {63'd0, in_ready}, 64'd1);
    check({name, " bcd hold idle"}, 64'(bcd_out), exp);
  endtask

  task automatic run_small(input logic [S_BIN_W-1:0] v);
    int          n;
    logic [63:0] full;
    logic [63:0] exp;
    logic        exp_ovf;
    full = to_bcd(64'(v), S_DIG);
`ifdef BCD_OVF_EN
    exp_ovf = (v >= 8'd100);
    exp     = exp_ovf ? 64'h99 : full;
`else
    exp_ovf = 1'b0;
    exp     = full;
`endif
    n = 0;
    s_in_valid = 1'b1;
    s_bin_in   = v;
    while (!s_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("small accept ready", {63'd0, s_in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    s_in_valid = 1'b0;
    n = 0;
    while (!s_out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("small latency", 64'(n), 64'(S_BIN_W));
    check("small bcd", 64'(s_bcd_out), exp);
`ifdef BCD_OVF_EN
    check("small ovf", {63'd0, s_ovf}, {63'd0, exp_ovf});
`else
    check("small no ovf model", {63'd0, exp_ovf}, {63'd0, s_out_valid & 1'b0});
`endif
    @(negedge clk);
    check("small valid drop", {63'd0, s_out_valid}, 64'd0);
  endtask

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic [63:0]      bcd;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rv;

    vecs[0] = '{32'd0,          64'h0000000000};
    vecs[1] = '{32'd299,        64'h0000000299};
    vecs[2] = '{32'd4294967295, 64'h4294967295};
    vecs[3] = '{32'd1,          64'h0000000001};
    vecs[4] = '{32'd9,          64'h0000000009};
    vecs[5] = '{32'd10,         64'h0000000010};
    vecs[6] = '{32'd1000000000, 64'h1000000000};
    vecs[7] = '{32'd2147483648, 64'h2147483648};
    vecs[8] = '{32'd99999999,   64'h0099999999};

    reset_n     = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    bin_in      = '0;
    s_in_valid  = 1'b0;
    s_out_ready = 1'b1;
    s_bin_in    = '0;
    repeat (3) @(negedge clk);
    check("reset in_ready", {63'd0, in_ready}, 64'd1);
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset bcd_out", 64'(bcd_out), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_main(vecs[i].bin, vecs[i].bcd, $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      rv = (i % 2 == 0) ? $urandom : $urandom_range(0, 99999);
      run_main(rv, to_bcd(64'(rv), DIGITS), $sformatf("rand%0d", i));
    end

    // Backpressure: result and flags must hold while out_ready is low.
    out_ready = 1'b0;
    accept_main(32'd12345);
    wait_valid_main(lat, 1'b0);
    check("bp latency", 64'(lat), 64'(BIN_W));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp bcd stable", 64'(bcd_out), 64'h12345);
      check("bp valid stable", {63'd0, out_valid}, 64'd1);
      check("bp in_ready low", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp release valid", {63'd0, out_valid}, 64'd0);
    check("bp release ready", {63'd0, in_ready}, 64'd1);

    // in_valid with changing data during SHIFT/DONE is ignored.
    accept_main(32'd777);
    wait_valid_main(lat, 1'b1);
    check("ignore latency", 64'(lat), 64'(BIN_W));
    check("ignore bcd", 64'(bcd_out), 64'h777);
    in_valid = 1'b1;
    bin_in   = 32'd4321;
    @(negedge clk);
    run_main(32'd4321, 64'h4321, "after ignore");

    // Asynchronous reset in the middle of a conversion.
    accept_main(32'd12345);
    repeat (16) @(negedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset in_ready", {63'd0, in_ready}, 64'd1);
    check("midreset out_valid", {63'd0, out_valid}, 64'd0);
    check("midreset bcd_out", 64'(bcd_out), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("postreset out_valid", {63'd0, out_valid}, 64'd0);
    run_main(32'd678, 64'h0000000678, "after reset");

    // Narrow instance: truncation (or saturation with overflow detection).
    run_small(8'd255);
    run_small(8'd99);
    run_small(8'd0);
    run_small(8'd100);
    run_small(8'd5);
    for (int i = 0; i < 6; i++) run_small(8'($urandom_range(0, 255)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
